// File: rtl/ysyx_22050550_ifu_if.sv
// Decode-side handshake of the instruction fetch unit.
// The IFU is master: it offers {pc, instr}, decode answers with ready.
interface ysyx_22050550_ifu_if #(
   parameter int PC_W   = 64,
   parameter int INST_W = 32
);
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_instr;

   modport master (
      output out_valid, out_pc, out_instr,
      input  out_ready
   );
   modport slave (
      input  out_valid, out_pc, out_instr,
      output out_ready
   );
endinterface

// File: rtl/ysyx_22050550_ifu.sv
// Instruction fetch unit: owns the PC, reads the ROM, and buffers
// {pc, instr} pairs for decode. Handles redirects and ebreak halting.
module ysyx_22050550_ifu #(
   parameter int              PC_W       = 64,
   parameter int              INST_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC   = 64'h8000_0000,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_en,
   output logic [PC_W-1:0]     instr_addr,
   input  logic [INST_W-1:0]   instr_i,
   input  logic                redirect_valid,
   input  logic [PC_W-1:0]     redirect_target,
   ysyx_22050550_ifu_if.master dec,
   output logic                misalign,
   output logic                halted
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0]     FULL_C  = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0]     PTR_ONE = AW'(1);
   localparam logic [PC_W-1:0]   PC_STEP = PC_W'(4);
   localparam logic [INST_W-1:0] EBREAK  = INST_W'(32'h0010_0073);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALT} state_e;

   state_e            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [AW-1:0]     wr_q, wr_d;
   logic [AW-1:0]     rd_q, rd_d;
   logic              mis_q, mis_d;
   logic              halt_q, halt_d;
   logic [PC_W-1:0]   pc_mem_q  [FIFO_DEPTH];
   logic [INST_W-1:0] ins_mem_q [FIFO_DEPTH];

   logic              push, pop, redir, valid;
   logic [PC_W-1:0]   tgt;
   logic [INST_W-1:0] head_instr;

   assign tgt        = {redirect_target[PC_W-1:2], 2'b00};
   assign head_instr = ins_mem_q[rd_q];
   assign valid      = (cnt_q != '0) && (state_q != HALT);
   // Redirects only act on a running pipe; HALT ignores them.
   assign redir      = redirect_valid &&
                       (state_q == RUN || state_q == DRAIN);
   // A redirect squashes the head, so it never counts as popped.
   assign pop        = valid && dec.out_ready && !redir;
   // Fullness uses the registered count: a pop frees no slot this cycle.
   assign push       = (state_q == RUN) && !redirect_valid &&
                       (cnt_q < FULL_C);

   assign instr_addr    = pc_q;
   assign dec.out_valid = valid;
   assign dec.out_pc    = pc_mem_q[rd_q];
   assign dec.out_instr = head_instr;
   assign misalign      = mis_q;
   assign halted        = halt_q;

   // Next-state: FSM, PC, FIFO pointers and sticky flags.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q + CW'(push) - CW'(pop);
      wr_d    = push ? wr_q + PTR_ONE : wr_q;
      rd_d    = pop ? rd_q + PTR_ONE : rd_q;
      mis_d   = mis_q;
      halt_d  = halt_q;
      unique case (state_q)
         IDLE: begin
            if (redirect_valid) pc_d = tgt;
            if (fetch_en) state_d = RUN;
         end
         RUN: begin
            if (push) begin
               pc_d = pc_q + PC_STEP;
               if (instr_i == EBREAK) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head_instr == EBREAK) begin
               halt_d  = 1'b1;
               state_d = HALT;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
      if (redir) begin
         cnt_d   = '0;
         wr_d    = rd_q;
         rd_d    = rd_q;
         pc_d    = tgt;
         state_d = RUN;
         if (redirect_target[1:0] != 2'b00) mis_d = 1'b1;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         mis_q   <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         mis_q   <= mis_d;
         halt_q  <= halt_d;
      end
   end

   // FIFO storage; cleared on reset so the head reads as zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pc_mem_q[i]  <= '0;
            ins_mem_q[i] <= '0;
         end
      end else if (push) begin
         pc_mem_q[wr_q]  <= pc_q;
         ins_mem_q[wr_q] <= instr_i;
      end
   end
endmodule

// File: tb/tb_ysyx_22050550_ifu.sv
// Bench for ysyx_22050550_ifu: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_ysyx_22050550_ifu;
   localparam int          DEPTH  = 2;
   localparam logic [31:0] EBK    = 32'h0010_0073;
   localparam logic [63:0] RST_PC = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic        redirect_valid;
   logic [63:0] redirect_target;
   logic [63:0] instr_addr;
   logic [31:0] instr_i;
   logic        misalign;
   logic        halted;
   logic [63:0] ebk_addr;

   int n_chk = 0;
   int n_err = 0;

   logic [63:0] m_pc;
   logic [95:0] m_q[$];
   bit          m_on, m_ebk, m_halt, m_mis;

   ysyx_22050550_ifu_if #(.PC_W(64), .INST_W(32)) dec ();

   ysyx_22050550_ifu dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fetch_en        (fetch_en),
      .instr_addr      (instr_addr),
      .instr_i         (instr_i),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .dec             (dec),
      .misalign        (misalign),
      .halted          (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(logic [63:0] a,
                                            logic [63:0] e);
      return (a == e) ? EBK : {a[13:2], 20'h00013};
   endfunction

   assign instr_i = rom_word(instr_addr, ebk_addr);

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      logic [95:0] hd;
      logic [31:0] w;
      bit          can;
      if (!rst_n) begin
         m_pc = RST_PC;
         m_q.delete();
         m_on = 0; m_ebk = 0; m_halt = 0; m_mis = 0;
      end else if (m_halt) begin
      end else if (!m_on) begin
         if (redirect_valid) m_pc = {redirect_target[63:2], 2'b00};
         if (fetch_en) m_on = 1;
      end else if (redirect_valid) begin
         m_q.delete();
         m_pc  = {redirect_target[63:2], 2'b00};
         m_ebk = 0;
         if (redirect_target[1:0] != 2'b00) m_mis = 1;
      end else begin
         can = !m_ebk && (m_q.size() < DEPTH);
         w   = rom_word(m_pc, ebk_addr);
         if (m_q.size() > 0 && dec.out_ready) begin
            hd = m_q.pop_front();
            if (hd[31:0] == EBK) m_halt = 1;
         end
         if (can) begin
            m_q.push_back({m_pc, w});
            m_pc = m_pc + 64'd4;
            if (w == EBK) m_ebk = 1;
         end
      end
   endtask

   task automatic compare();
      bit v;
      v = (m_q.size() > 0) && !m_halt;
      chk("instr_addr", instr_addr, m_pc);
      chk("out_valid", dec.out_valid, v);
      chk("misalign", misalign, m_mis);
      chk("halted", halted, m_halt);
      if (v) begin
         chk("out_pc", dec.out_pc, m_q[0][95:32]);
         chk("out_instr", dec.out_instr, m_q[0][31:0]);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      rst_n = 0; fetch_en = 0; redirect_valid = 0;
      redirect_target = '0; dec.out_ready = 1; ebk_addr = '0;
      tick(); tick();
      chk("rst_pc", dec.out_pc, 64'h0);
      chk("rst_instr", dec.out_instr, 64'h0);
      chk("rst_addr", instr_addr, RST_PC);

      rst_n = 1; fetch_en = 1;
      tick();
      fetch_en = 0;
      chk("idle_gap", dec.out_valid, 1'b0);
      tick(); chk("seq0", dec.out_pc, 64'h8000_0000);
      tick(); chk("seq1", dec.out_pc, 64'h8000_0004);
      tick(); chk("seq2", dec.out_pc, 64'h8000_0008);

      dec.out_ready = 0;
      repeat (5) tick();
      chk("stall_addr", instr_addr, 64'h8000_0010);
      chk("stall_pc", dec.out_pc, 64'h8000_0008);
      dec.out_ready = 1;
      repeat (4) tick();

      dec.out_ready = 0;
      tick(); tick();
      redirect_valid = 1; redirect_target = 64'h8000_0100;
      dec.out_ready = 1;
      tick();
      redirect_valid = 0;
      chk("flush_valid", dec.out_valid, 1'b0);
      chk("flush_addr", instr_addr, 64'h8000_0100);
      tick();
      chk("tgt_pc", dec.out_pc, 64'h8000_0100);

      redirect_valid = 1; redirect_target = 64'h8000_0102;
      tick();
      redirect_valid = 0;
      chk("mis_flag", misalign, 1'b1);
      chk("mis_addr", instr_addr, 64'h8000_0100);
      repeat (3) tick();
      chk("mis_sticky", misalign, 1'b1);

      rst_n = 0;
      tick();
      rst_n = 1;
      chk("mid_rst_addr", instr_addr, RST_PC);
      chk("mid_rst_valid", dec.out_valid, 1'b0);
      chk("mid_rst_pc", dec.out_pc, 64'h0);
      chk("mid_rst_mis", misalign, 1'b0);

      ebk_addr = 64'h8000_0008;
      fetch_en = 1;
      tick();
      fetch_en = 0;
      repeat (6) tick();
      chk("ebk_halt", halted, 1'b1);
      chk("ebk_addr", instr_addr, 64'h8000_000C);
      redirect_valid = 1; redirect_target = 64'h8000_0300;
      tick();
      redirect_valid = 0;
      chk("halt_ignore", instr_addr, 64'h8000_000C);
      chk("halt_valid", dec.out_valid, 1'b0);

      rst_n = 0;
      tick();
      rst_n = 1; ebk_addr = 64'h8000_0004;
      fetch_en = 1; dec.out_ready = 0;
      tick();
      fetch_en = 0;
      tick(); tick(); tick();
      redirect_valid = 1; redirect_target = 64'h8000_0200;
      tick();
      redirect_valid = 0; dec.out_ready = 1;
      chk("spec_halt", halted, 1'b0);
      tick();
      chk("spec_pc", dec.out_pc, 64'h8000_0200);
      repeat (4) tick();
      chk("spec_nohalt", halted, 1'b0);

      for (int i = 0; i < 400; i++) begin
         rst_n          = ($urandom_range(0, 99) != 0);
         fetch_en       = ($urandom_range(0, 3) == 0);
         redirect_valid = ($urandom_range(0, 11) == 0);
         redirect_target = {32'h0,
                            32'h8000_0000 + $urandom_range(0, 1023)};
         dec.out_ready  = ($urandom_range(0, 3) != 0);
         if (!rst_n)
            ebk_addr = {32'h0,
                        32'h8000_0000 + 4 * $urandom_range(1, 30)};
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
